// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
// The state enum gains PAUSE only when SEQ_SINGLE_STEP_EN is defined.
package seq_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int OPC_W_DEF  = 4;

  localparam logic [OPC_W_DEF-1:0] OPC_NOP  = 4'h0;
  localparam logic [OPC_W_DEF-1:0] OPC_JMP  = 4'hC;
  localparam logic [OPC_W_DEF-1:0] OPC_JZ   = 4'hD;
  localparam logic [OPC_W_DEF-1:0] OPC_JN   = 4'hE;
  localparam logic [OPC_W_DEF-1:0] OPC_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_DECODE,
    S_EXEC,
    S_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } seq_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the sequencer (master) and memory/datapath/PC (slave).
// The step signal exists only when SEQ_SINGLE_STEP_EN is defined.
interface instr_sequencer_if #(parameter int ADDR_W = 10);
  logic              start;
  logic [31:0]       instr;
  logic [1:0]        status;
  logic              exec_busy;
  logic              im_r;
  logic              ir_load;
  logic              inc_en;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              exec_start;
  logic              halted;
  logic [15:0]       instr_count;
`ifdef SEQ_SINGLE_STEP_EN
  logic              step;
`endif

  modport master (
    input  start, instr, status, exec_busy,
`ifdef SEQ_SINGLE_STEP_EN
    input  step,
`endif
    output im_r, ir_load, inc_en, pc_load, pc_load_addr, exec_start, halted, instr_count
  );

  modport slave (
    output start, instr, status, exec_busy,
`ifdef SEQ_SINGLE_STEP_EN
    output step,
`endif
    input  im_r, ir_load, inc_en, pc_load, pc_load_addr, exec_start, halted, instr_count
  );
endinterface

// File: rtl/instr_sequencer_wait_ctr.sv
// Memory-latency down-counter: load with MEM_LAT, decrement while waiting, done at 1.
module seq_wait_ctr #(
  parameter int MEM_LAT = 1
) (
  input  logic clock,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);
  logic [2:0] cnt_q;

  always_ff @(posedge clock) begin
    if (rst)                        cnt_q <= '0;
    else if (load_i)                cnt_q <= 3'(MEM_LAT);
    else if (dec_i && cnt_q != '0)  cnt_q <= cnt_q - 3'd1;
  end

  assign done_o = (cnt_q == 3'd1);
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer; every output is a register, pulses last one cycle.
// Macro SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state ahead of each refetch.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OPC_W   = OPC_W_DEF,
  parameter int MEM_LAT = 1
) (
  input logic               clock,
  input logic               rst,
  instr_sequencer_if.master bus
);
  seq_state_t        state_q;
  logic [OPC_W-1:0]  opc_q;
  logic [ADDR_W-1:0] tgt_q, pc_addr_q;
  logic              im_r_q, ir_load_q, inc_en_q, pc_load_q, exec_start_q, halted_q;
  logic [15:0]       count_q;
  logic              wait_done, br_taken;

`ifdef SEQ_SINGLE_STEP_EN
  localparam seq_state_t S_NEXT = S_PAUSE;
`else
  localparam seq_state_t S_NEXT = S_FETCH;
`endif

  seq_wait_ctr #(.MEM_LAT(MEM_LAT)) u_wait (
    .clock (clock),
    .rst   (rst),
    .load_i(state_q == S_FETCH),
    .dec_i (state_q == S_WAIT_MEM),
    .done_o(wait_done)
  );

  always_comb
    br_taken = (opc_q == OPC_W'(OPC_JZ) && bus.status[0]) ||
               (opc_q == OPC_W'(OPC_JN) && bus.status[1]);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= S_IDLE;
      opc_q        <= '0;
      tgt_q        <= '0;
      pc_addr_q    <= '0;
      im_r_q       <= 1'b0;
      ir_load_q    <= 1'b0;
      inc_en_q     <= 1'b0;
      pc_load_q    <= 1'b0;
      exec_start_q <= 1'b0;
      halted_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      im_r_q       <= (state_q == S_FETCH);
      ir_load_q    <= 1'b0;
      inc_en_q     <= 1'b0;
      pc_load_q    <= 1'b0;
      exec_start_q <= 1'b0;
      case (state_q)
        S_IDLE:  if (bus.start) state_q <= S_FETCH;
        S_FETCH: state_q <= S_WAIT_MEM;
        S_WAIT_MEM: if (wait_done) begin
          ir_load_q <= 1'b1;
          opc_q     <= bus.instr[31 -: OPC_W];
          tgt_q     <= bus.instr[ADDR_W-1:0];
          state_q   <= S_DECODE;
        end
        S_DECODE: begin
          case (opc_q)
            OPC_W'(OPC_HALT): begin
              halted_q <= 1'b1;
              count_q  <= sat_inc16(count_q);
              state_q  <= S_HALT;
            end
            OPC_W'(OPC_JMP): begin
              pc_load_q <= 1'b1;
              pc_addr_q <= tgt_q;
              count_q   <= sat_inc16(count_q);
              state_q   <= S_NEXT;
            end
            OPC_W'(OPC_JZ), OPC_W'(OPC_JN): begin
              pc_load_q <= br_taken;
              inc_en_q  <= !br_taken;
              if (br_taken) pc_addr_q <= tgt_q;
              count_q   <= sat_inc16(count_q);
              state_q   <= S_NEXT;
            end
            default: begin
              exec_start_q <= 1'b1;
              state_q      <= S_EXEC;
            end
          endcase
        end
        // exec_busy is not yet valid in the exec_start cycle, so that cycle is skipped
        S_EXEC: if (!exec_start_q && !bus.exec_busy) begin
          inc_en_q <= 1'b1;
          count_q  <= sat_inc16(count_q);
          state_q  <= S_NEXT;
        end
        S_HALT: state_q <= S_HALT;
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: if (bus.step) state_q <= S_FETCH;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.im_r         = im_r_q;
  assign bus.ir_load      = ir_load_q;
  assign bus.inc_en       = inc_en_q;
  assign bus.pc_load      = pc_load_q;
  assign bus.pc_load_addr = pc_addr_q;
  assign bus.exec_start   = exec_start_q;
  assign bus.halted       = halted_q;
  assign bus.instr_count  = count_q;
endmodule
